// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: oversampling UART receiver (majority-vote sampling, parity, 1/2 stop bits).
// Define UART_RX_BREAK_DET_EN to add break detection (BRK output and WAIT_HIGH state).
module uart_rx_frame_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESC_W-1:0]    PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  TWO_STOP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR,
`ifdef UART_RX_BREAK_DET_EN
  output logic                  BRK,
`endif
  output logic                  BUSY
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    START  = 3'b001,
    DATA   = 3'b011,
    PARITY = 3'b010,
    STOP   = 3'b110
`ifdef UART_RX_BREAK_DET_EN
    , WAIT_HIGH = 3'b111
`endif
  } state_t;

  state_t                  state_reg;
  logic [PRESC_W-1:0]      edge_cnt_reg;
  logic [BIT_W-1:0]        bit_cnt_reg;
  logic                    stop_cnt_reg;
  logic [PRESC_W-1:0]      presc_reg;
  logic                    par_en_reg;
  logic                    par_typ_reg;
  logic                    two_stop_reg;
  logic [2:0]              samp_reg;
  logic [DATA_WIDTH-1:0]   shift_reg;
  logic                    par_fail_reg;
  logic                    stp_fail_reg;
  logic                    res_pend_reg;
  logic                    res_par_reg;
  logic                    res_stp_reg;
  logic [DATA_WIDTH-1:0]   p_data_reg;
  logic                    data_valid_reg;
  logic                    par_err_reg;
  logic                    stp_err_reg;
`ifdef UART_RX_BREAK_DET_EN
  logic                    par_bit_reg;
  logic                    res_brk_reg;
  logic                    brk_reg;
  logic                    brk_cond;
`endif

  logic [PRESC_W-1:0] presc_clamped;
  logic [PRESC_W-1:0] half_cnt;
  logic               at_boundary;
  logic               samp2_eff;
  logic               bit_val;

  assign presc_clamped = (PRESCALE < PRESC_W'(4)) ? PRESC_W'(4) : PRESCALE;
  assign half_cnt      = presc_reg >> 1;
  assign at_boundary   = (edge_cnt_reg == presc_reg - PRESC_W'(1));
  // With P=4 the last sample lands on the boundary cycle, so vote on the live input there.
  assign samp2_eff     = (edge_cnt_reg == half_cnt + PRESC_W'(1)) ? RX_IN : samp_reg[2];
  assign bit_val       = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & samp2_eff) |
                         (samp_reg[1] & samp2_eff);

`ifdef UART_RX_BREAK_DET_EN
  assign brk_cond = (shift_reg == '0) && (!par_en_reg || !par_bit_reg) && !bit_val;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg      <= IDLE;
      edge_cnt_reg   <= '0;
      bit_cnt_reg    <= '0;
      stop_cnt_reg   <= 1'b0;
      presc_reg      <= PRESC_W'(4);
      par_en_reg     <= 1'b0;
      par_typ_reg    <= 1'b0;
      two_stop_reg   <= 1'b0;
      samp_reg       <= '0;
      shift_reg      <= '0;
      par_fail_reg   <= 1'b0;
      stp_fail_reg   <= 1'b0;
      res_pend_reg   <= 1'b0;
      res_par_reg    <= 1'b0;
      res_stp_reg    <= 1'b0;
      p_data_reg     <= '0;
      data_valid_reg <= 1'b0;
      par_err_reg    <= 1'b0;
      stp_err_reg    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      par_bit_reg    <= 1'b0;
      res_brk_reg    <= 1'b0;
      brk_reg        <= 1'b0;
`endif
    end else begin
      data_valid_reg <= 1'b0;
      par_err_reg    <= 1'b0;
      stp_err_reg    <= 1'b0;
      res_pend_reg   <= 1'b0;
      res_par_reg    <= 1'b0;
      res_stp_reg    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      brk_reg        <= 1'b0;
      res_brk_reg    <= 1'b0;
`endif

      // Frame result is staged one cycle so every output comes straight from a register.
      if (res_pend_reg) begin
`ifdef UART_RX_BREAK_DET_EN
        if (res_brk_reg) brk_reg <= 1'b1;
        else
`endif
        if (res_par_reg || res_stp_reg) begin
          par_err_reg <= res_par_reg;
          stp_err_reg <= res_stp_reg;
        end else begin
          data_valid_reg <= 1'b1;
          p_data_reg     <= shift_reg;
        end
      end

      if (state_reg != IDLE) begin
        if (edge_cnt_reg == half_cnt - PRESC_W'(1)) samp_reg[0] <= RX_IN;
        if (edge_cnt_reg == half_cnt)               samp_reg[1] <= RX_IN;
        if (edge_cnt_reg == half_cnt + PRESC_W'(1)) samp_reg[2] <= RX_IN;
        edge_cnt_reg <= at_boundary ? '0 : edge_cnt_reg + PRESC_W'(1);
      end

      case (state_reg)
        IDLE: begin
          if (!RX_IN) begin
            state_reg    <= START;
            edge_cnt_reg <= PRESC_W'(1);
            presc_reg    <= presc_clamped;
            par_en_reg   <= PAR_EN;
            par_typ_reg  <= PAR_TYP;
            two_stop_reg <= TWO_STOP;
            bit_cnt_reg  <= '0;
            stop_cnt_reg <= 1'b0;
            par_fail_reg <= 1'b0;
            stp_fail_reg <= 1'b0;
          end
        end
        START: begin
          if (at_boundary) state_reg <= bit_val ? IDLE : DATA;
        end
        DATA: begin
          if (at_boundary) begin
            shift_reg <= {bit_val, shift_reg[DATA_WIDTH-1:1]};
            if (bit_cnt_reg == LAST_BIT) begin
              bit_cnt_reg <= '0;
              state_reg   <= par_en_reg ? PARITY : STOP;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
            end
          end
        end
        PARITY: begin
          if (at_boundary) begin
            par_fail_reg <= (bit_val != ((^shift_reg) ^ par_typ_reg));
`ifdef UART_RX_BREAK_DET_EN
            par_bit_reg  <= bit_val;
`endif
            state_reg    <= STOP;
          end
        end
        STOP: begin
          if (at_boundary) begin
`ifdef UART_RX_BREAK_DET_EN
            if (!stop_cnt_reg && brk_cond) begin
              state_reg    <= WAIT_HIGH;
              res_pend_reg <= 1'b1;
              res_brk_reg  <= 1'b1;
            end else
`endif
            if (two_stop_reg && !stop_cnt_reg) begin
              stop_cnt_reg <= 1'b1;
              stp_fail_reg <= ~bit_val;
            end else begin
              state_reg    <= IDLE;
              res_pend_reg <= 1'b1;
              res_par_reg  <= par_fail_reg;
              res_stp_reg  <= stp_fail_reg | ~bit_val;
            end
          end
        end
`ifdef UART_RX_BREAK_DET_EN
        WAIT_HIGH: begin
          // Counts consecutive high cycles; any low restarts the full bit time.
          if (!RX_IN) begin
            edge_cnt_reg <= '0;
          end else if (edge_cnt_reg == presc_reg - PRESC_W'(1)) begin
            state_reg    <= IDLE;
            edge_cnt_reg <= '0;
          end else begin
            edge_cnt_reg <= edge_cnt_reg + PRESC_W'(1);
          end
        end
`endif
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign P_DATA     = p_data_reg;
  assign DATA_VALID = data_valid_reg;
  assign PAR_ERR    = par_err_reg;
  assign STP_ERR    = stp_err_reg;
  assign BUSY       = (state_reg != IDLE);
`ifdef UART_RX_BREAK_DET_EN
  assign BRK        = brk_reg;
`endif

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed testbench for uart_rx_frame_ctrl (default build, DATA_WIDTH=8, PRESC_W=6).
module tb_uart_rx_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [5:0] prescale;
  logic       par_en;
  logic       par_typ;
  logic       two_stop;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int dv_cnt = 0;
  int pe_cnt = 0;
  int se_cnt = 0;
  int last_dv_cyc = 0;
  logic [7:0] dv_hist [0:31];

  int dv0, pe0, se0, t0, t2;

  uart_rx_frame_ctrl #(.DATA_WIDTH(8), .PRESC_W(6)) dut (
    .CLK        (clk),
    .RST        (rst),
    .RX_IN      (rx_in),
    .PRESCALE   (prescale),
    .PAR_EN     (par_en),
    .PAR_TYP    (par_typ),
    .TWO_STOP   (two_stop),
    .P_DATA     (p_data),
    .DATA_VALID (data_valid),
    .PAR_ERR    (par_err),
    .STP_ERR    (stp_err),
    .BUSY       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts result pulses and logs every delivered byte.
  always @(negedge clk) begin
    if (data_valid) begin
      dv_hist[dv_cnt % 32] <= p_data;
      dv_cnt               <= dv_cnt + 1;
      last_dv_cyc          <= cyc;
    end
    if (par_err) pe_cnt <= pe_cnt + 1;
    if (stp_err) se_cnt <= se_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    dv0 = dv_cnt;
    pe0 = pe_cnt;
    se0 = se_cnt;
    t0  = cyc;
  endtask

  task automatic drive_bit(input logic v, input int n);
    rx_in = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends start, 8 data bits LSB first, optional parity, one or two stop bits.
  // corrupt_bit: frame bit index whose centre sample is inverted (-1 = none).
  // sw_bit: frame bit index at whose start PRESCALE is changed to sw_val (-1 = none).
  task automatic send_frame(input logic [7:0] data, input int p, input bit par_on,
                            input logic par_bit, input logic stop1, input bit two,
                            input logic stop2, input int corrupt_bit, input int sw_bit,
                            input logic [5:0] sw_val);
    logic fb [0:15];
    int n;
    fb[0] = 1'b0;
    n = 1;
    for (int i = 0; i < 8; i++) begin
      fb[n] = data[i];
      n++;
    end
    if (par_on) begin
      fb[n] = par_bit;
      n++;
    end
    fb[n] = stop1;
    n++;
    if (two) begin
      fb[n] = stop2;
      n++;
    end
    $display("tx frame data=0x%02h p=%0d par=%0d/%0b stop=%0b%0s", data, p, par_on, par_bit,
             stop1, two ? (stop2 ? ",1" : ",0") : "");
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < p; c++) begin
        if (b == sw_bit && c == 0) prescale = sw_val;
        rx_in = (b == corrupt_bit && c == p / 2) ? ~fb[b] : fb[b];
        @(posedge clk);
        #1;
      end
    end
    rx_in = 1'b1;
  endtask

  initial begin
    rst = 1'b1; rx_in = 1'b1; prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0; two_stop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pdata", p_data, 8'h00);
    check("rst_dv", data_valid, 1'b0);
    check("rst_perr", par_err, 1'b0);
    check("rst_serr", stp_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    drive_bit(1'b1, 4);

    // 8N1 at P=8
    snap();
    send_frame(8'hA5, 8, 0, 1'b0, 1'b1, 0, 1'b1, -1, -1, 6'd0);
    drive_bit(1'b1, 4);
    check("t1_dv_count", dv_cnt - dv0, 1);
    check("t1_latency", last_dv_cyc - t0, 81);
    check("t1_pdata", p_data, 8'hA5);
    check("t1_no_err", (pe_cnt - pe0) + (se_cnt - se0), 0);
    check("t1_busy", busy, 1'b0);

    // 8E1 / 8O1 at P=16
    prescale = 6'd16; par_en = 1'b1; par_typ = 1'b0;
    snap();
    send_frame(8'h3C, 16, 1, 1'b0, 1'b1, 0, 1'b1, -1, -1, 6'd0);
    drive_bit(1'b1, 4);
    check("t2_even_ok_dv", dv_cnt - dv0, 1);
    check("t2_even_ok_pdata", p_data, 8'h3C);
    check("t2_even_ok_perr", pe_cnt - pe0, 0);
    snap();
    send_frame(8'h3C, 16, 1, 1'b1, 1'b1, 0, 1'b1, -1, -1, 6'd0);
    drive_bit(1'b1, 4);
    check("t2_even_bad_perr", pe_cnt - pe0, 1);
    check("t2_even_bad_dv", dv_cnt - dv0, 0);
    check("t2_even_bad_serr", se_cnt - se0, 0);
    check("t2_even_bad_pdata", p_data, 8'h3C);
    par_typ = 1'b1;
    snap();
    send_frame(8'h07, 16, 1, 1'b0, 1'b1, 0, 1'b1, -1, -1, 6'd0);
    drive_bit(1'b1, 4);
    check("t2_odd_ok_dv", dv_cnt - dv0, 1);
    check("t2_odd_ok_pdata", p_data, 8'h07);

    // Two stop bits, P=8
    prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0; two_stop = 1'b1;
    snap();
    send_frame(8'h81, 8, 0, 1'b0, 1'b1, 1, 1'b0, -1, -1, 6'd0);
    drive_bit(1'b1, 4);
    check("t3_serr", se_cnt - se0, 1);
    check("t3_dv", dv_cnt - dv0, 0);
    check("t3_pdata_hold", p_data, 8'h07);
    check("t3_busy", busy, 1'b0);
    snap();
    send_frame(8'h81, 8, 0, 1'b0, 1'b1, 1, 1'b1, -1, -1, 6'd0);
    drive_bit(1'b1, 4);
    check("t3_good_dv", dv_cnt - dv0, 1);
    check("t3_good_pdata", p_data, 8'h81);
    two_stop = 1'b0;

    // Glitch on the start bit
    snap();
    drive_bit(1'b0, 3);
    check("t4_glitch_busy_hi", busy, 1'b1);
    drive_bit(1'b1, 4);
    check("t4_glitch_busy_c7", busy, 1'b1);
    drive_bit(1'b1, 1);
    check("t4_glitch_busy_lo", busy, 1'b0);
    drive_bit(1'b1, 12);
    check("t4_glitch_pulses", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0), 0);

    // Majority vote: centre sample of data bit 1 inverted
    snap();
    send_frame(8'h5A, 8, 0, 1'b0, 1'b1, 0, 1'b1, 2, -1, 6'd0);
    drive_bit(1'b1, 4);
    check("t4_maj_dv", dv_cnt - dv0, 1);
    check("t4_maj_pdata", p_data, 8'h5A);

    // Zero byte with low stop bit, line held low: STP_ERR then immediate restart
    snap();
    send_frame(8'h00, 8, 0, 1'b0, 1'b0, 0, 1'b1, -1, -1, 6'd0);
    drive_bit(1'b0, 2);
    check("t4_brk_restart_busy", busy, 1'b1);
    drive_bit(1'b1, 16);
    check("t4_brk_serr", se_cnt - se0, 1);
    check("t4_brk_dv", dv_cnt - dv0, 0);
    check("t4_brk_pdata_hold", p_data, 8'h5A);
    check("t4_brk_idle", busy, 1'b0);

    // Back-to-back with PRESCALE switched 8->16 inside frame 1
    snap();
    send_frame(8'h55, 8, 0, 1'b0, 1'b1, 0, 1'b1, -1, 5, 6'd16);
    t2 = cyc;
    send_frame(8'hAA, 16, 0, 1'b0, 1'b1, 0, 1'b1, -1, -1, 6'd0);
    drive_bit(1'b1, 4);
    check("t5_dv_count", dv_cnt - dv0, 2);
    check("t5_first", dv_hist[dv0 % 32], 8'h55);
    check("t5_second", dv_hist[(dv0 + 1) % 32], 8'hAA);
    check("t5_f2_latency", last_dv_cyc - t2, 161);

    // Reset during data bit 4
    prescale = 6'd8;
    snap();
    drive_bit(1'b0, 8);
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 8);
    drive_bit(1'b1, 8);
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 4);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t6_rst_pdata", p_data, 8'h00);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_dv", data_valid, 1'b0);
    drive_bit(1'b1, 24);
    check("t6_rst_pulses", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0), 0);
    snap();
    send_frame(8'h0F, 8, 0, 1'b0, 1'b1, 0, 1'b1, -1, -1, 6'd0);
    drive_bit(1'b1, 4);
    check("t6_after_dv", dv_cnt - dv0, 1);
    check("t6_after_pdata", p_data, 8'h0F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
- Parametrised UART receive controller. It integrates oversampling, majority-vote bit sampling, deserialisation, parity check and stop check behind one frame FSM.
- Generalises the fixed 8-bit receiver to:
  - configurable data width;
  - runtime parity enable and type (even/odd);
  - one or two stop bits;
  - runtime oversampling ratio.
- Sits between the RX_IN pad synchroniser and the RX data consumer (register file / sync FIFO). Lives in the UART_CLK domain.

Parameters:
- DATA_WIDTH, 8, data bits per frame; legal 5..9.
- PRESC_W, 6, width of PRESCALE input; max oversampling ratio 2^PRESC_W-1.

Ports:
- CLK  in  1  receiver clock (oversampling clock).
- RST  in  1  synchronous, active-high reset.
- RX_IN  in  1  serial input, already synchronised to CLK, idle high.
- PRESCALE  in  PRESC_W  CLK cycles per bit; values <4 treated as 4.
- PAR_EN  in  1  1 = parity bit present.
- PAR_TYP  in  1  0 = even, 1 = odd.
- TWO_STOP  in  1  1 = two stop bits.
- P_DATA  out  DATA_WIDTH  last good frame, LSB = first received bit.
- DATA_VALID  out  1  one-cycle pulse, P_DATA updated.
- PAR_ERR  out  1  one-cycle pulse, frame dropped on parity mismatch.
- STP_ERR  out  1  one-cycle pulse, frame dropped on stop bit sampled 0.
- BUSY  out  1  high while FSM not in IDLE.

Behaviour:
- Reset:
  - One clock with RST=1 forces the FSM to IDLE, clears all counters, and drives every output to 0 (including P_DATA).
  - Reset mid-frame abandons the frame with no pulses.
- Config latching: PRESCALE, PAR_EN, PAR_TYP and TWO_STOP are latched on the IDLE->START transition. Changes mid-frame are ignored until the next frame.
- Edge counter:
  - Cleared on every bit boundary and counts 0..P-1 (P = latched, clamped PRESCALE).
  - Bit boundary occurs when the counter equals P-1.
- Sampling:
  - RX_IN is captured at counter values P/2-1, P/2 and P/2+1 (integer divide).
  - The bit value is the 2-of-3 majority, resolved by the bit boundary.
- Bit counter: counts received bits within the DATA state, 0..DATA_WIDTH-1.
- FSM states (Gray-encoded):
  - IDLE:
    - RX_IN==0 -> START, counter cleared.
    - The detection cycle counts as edge 0 of the start bit.
  - START, at the bit boundary:
    - sampled 1 -> IDLE (glitch rejected, no pulses);
    - sampled 0 -> DATA.
  - DATA:
    - Shift the sampled bit in LSB-first at each boundary.
    - After DATA_WIDTH bits: -> PARITY if PAR_EN, else -> STOP.
  - PARITY:
    - Expected parity = XOR of data bits, inverted when PAR_TYP=1.
    - A mismatch sets the internal par_fail flag.
    - At the boundary -> STOP.
  - STOP:
    - One or two bits (TWO_STOP).
    - Any stop bit sampled 0 sets the internal stp_fail flag.
    - At the boundary of the last stop bit -> IDLE.
- Frame result (on the STOP->IDLE transition):
  - Outputs are registered and appear in the following cycle, i.e. one cycle after the last stop-bit boundary.
  - No fail flag: P_DATA <= shift register, DATA_VALID=1.
  - Otherwise: P_DATA holds its previous value, and PAR_ERR and/or STP_ERR = 1. Both may pulse together.
  - DATA_VALID and the error pulses are mutually exclusive.
- Back-to-back frames:
  - IDLE accepts a start edge in the same cycle the result pulses.
  - A new frame is never missed when the stop bit is followed immediately by a start bit.
- BUSY = (state != IDLE).
- No consumer handshake exists: the consumer must capture P_DATA on DATA_VALID. P_DATA remains stable until the next good frame.

Optional Feature:
- Macro: UART_RX_BREAK_DET_EN.
- Defined:
  - Adds output BRK (1 bit, reset 0) and state WAIT_HIGH.
  - A frame with all data bits 0, parity sampled 0 (if enabled) and first stop bit sampled 0 produces a one-cycle BRK pulse instead of STP_ERR/PAR_ERR.
  - The FSM then enters WAIT_HIGH and returns to IDLE only after RX_IN==1 for one full bit time (P cycles).
- Undefined:
  - No BRK port.
  - The same line condition reports STP_ERR.
  - The FSM returns to IDLE and, with RX_IN still 0, immediately starts a new frame.

Test Plan:
1. Basic receive, 8N1: DATA_WIDTH=8, PRESCALE=8, PAR_EN=0, TWO_STOP=0, send 0xA5 -> DATA_VALID pulses exactly once, 81 cycles after start edge; P_DATA=0xA5; no error pulses.
2. Parity, 8E1: PAR_EN=1, PAR_TYP=0, PRESCALE=16:
   - 0x3C with parity bit 0 -> DATA_VALID, P_DATA=0x3C.
   - Same byte with parity bit 1 -> PAR_ERR pulse only, P_DATA stays 0x3C.
3. Two stop bits, stop error: TWO_STOP=1, send 0x81 with second stop bit 0 -> STP_ERR pulse; DATA_VALID stays 0; FSM back in IDLE.
4. Glitch and majority vote, PRESCALE=8:
   - Start low for 3 cycles only -> no pulses, BUSY drops after 8 cycles.
   - A data bit with one corrupted centre sample -> still received correctly.
5. Back-to-back with config change mid-frame: 0x55 immediately followed by 0xAA; PRESCALE changed 8->16 during frame 1 -> frame 1 received at 8, frame 2 at 16; two DATA_VALID pulses, values 0x55 then 0xAA.
6. Reset mid-frame: RST=1 for one cycle at bit 4 of a frame -> all outputs 0, BUSY=0, no pulses; next clean frame 0x0F received correctly.
